// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: load-use hazard detection,
// bubble injection on stall/flush, and the forwarded EX operand muxes.
module id_ex_hazard_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_alusrc,
    input  logic [3:0]       id_aluop,
    input  logic             flush,
    input  logic [1:0]       forwardA,
    input  logic [1:0]       forwardB,
    input  logic [XLEN-1:0]  ex_mem_alu_result,
    input  logic [XLEN-1:0]  wb_data,
    output logic             stall_if_id,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_alusrc,
    output logic [3:0]       ex_aluop,
    output logic [XLEN-1:0]  ex_op_a,
    output logic [XLEN-1:0]  ex_op_b,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [CNT_W-1:0] stall_count
);

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic             r_regwrite;
    logic             r_memread;
    logic             r_memwrite;
    logic             r_alusrc;
    logic [3:0]       r_aluop;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_hazard;
    logic             w_stall;
    logic             w_bubble;
    logic [XLEN-1:0]  w_op_a;
    logic [XLEN-1:0]  w_fwd_b;

    assign w_hazard = r_valid & r_memread & (r_rd != '0) & id_valid &
                      ((r_rd == id_rs1) | (r_rd == id_rs2));
    assign w_stall  = w_hazard & ~flush & ~reset;
    assign w_bubble = flush | w_hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_regwrite    <= 1'b0;
            r_memread     <= 1'b0;
            r_memwrite    <= 1'b0;
            r_alusrc      <= 1'b0;
            r_aluop       <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_bubble) begin
                r_valid    <= 1'b0;
                r_pc       <= '0;
                r_rs1      <= '0;
                r_rs2      <= '0;
                r_rd       <= '0;
                r_rs1_data <= '0;
                r_rs2_data <= '0;
                r_imm      <= '0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_alusrc   <= 1'b0;
                r_aluop    <= '0;
            end else begin
                r_valid    <= id_valid;
                r_pc       <= id_pc;
                r_rs1      <= id_rs1;
                r_rs2      <= id_rs2;
                r_rd       <= id_rd;
                r_rs1_data <= id_rs1_data;
                r_rs2_data <= id_rs2_data;
                r_imm      <= id_imm;
                // An empty ID slot must not carry live control into EX.
                r_regwrite <= id_valid & id_regwrite;
                r_memread  <= id_valid & id_memread;
                r_memwrite <= id_valid & id_memwrite;
                r_alusrc   <= id_valid & id_alusrc;
                r_aluop    <= id_valid ? id_aluop : 4'd0;
            end
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_op_a = r_rs1_data;
        case (forwardA)
            2'b10:   w_op_a = ex_mem_alu_result;
            2'b01:   w_op_a = wb_data;
            default: w_op_a = r_rs1_data;
        endcase
    end

    always_comb begin
        w_fwd_b = r_rs2_data;
        case (forwardB)
            2'b10:   w_fwd_b = ex_mem_alu_result;
            2'b01:   w_fwd_b = wb_data;
            default: w_fwd_b = r_rs2_data;
        endcase
    end

    assign stall_if_id   = w_stall;
    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_rs1        = r_rs1;
    assign ex_rs2        = r_rs2;
    assign ex_rd         = r_rd;
    assign ex_regwrite   = r_regwrite;
    assign ex_memread    = r_memread;
    assign ex_memwrite   = r_memwrite;
    assign ex_alusrc     = r_alusrc;
    assign ex_aluop      = r_aluop;
    assign ex_op_a       = w_op_a;
    assign ex_op_b       = r_alusrc ? r_imm : w_fwd_b;
    assign ex_store_data = w_fwd_b;
    assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench for id_ex_hazard_stage: a transaction-level model of the EX slot
// predicts every cycle's outputs; a separate monitor pops and compares them.
module tb_id_ex_hazard_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_regwrite, id_memread, id_memwrite, id_alusrc;
    logic [3:0]  id_aluop;
    logic        flush;
    logic [1:0]  forwardA, forwardB;
    logic [31:0] ex_mem_alu_result, wb_data;

    logic        stall_if_id, ex_valid;
    logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_store_data, stall_count;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_alusrc;
    logic [3:0]  ex_aluop;

    logic        stall_4, valid_4;
    logic [31:0] pc_4, op_a_4, op_b_4, store_4;
    logic [4:0]  rs1_4, rs2_4, rd_4;
    logic        rw_4, mr_4, mw_4, as_4;
    logic [3:0]  aluop_4;
    logic [3:0]  count_4;

    always #5 clk = ~clk;

    id_ex_hazard_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_alusrc(id_alusrc), .id_aluop(id_aluop), .flush(flush),
        .forwardA(forwardA), .forwardB(forwardB),
        .ex_mem_alu_result(ex_mem_alu_result), .wb_data(wb_data),
        .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_store_data(ex_store_data), .stall_count(stall_count)
    );

    id_ex_hazard_stage #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_alusrc(id_alusrc), .id_aluop(id_aluop), .flush(flush),
        .forwardA(forwardA), .forwardB(forwardB),
        .ex_mem_alu_result(ex_mem_alu_result), .wb_data(wb_data),
        .stall_if_id(stall_4), .ex_valid(valid_4), .ex_pc(pc_4),
        .ex_rs1(rs1_4), .ex_rs2(rs2_4), .ex_rd(rd_4),
        .ex_regwrite(rw_4), .ex_memread(mr_4), .ex_memwrite(mw_4),
        .ex_alusrc(as_4), .ex_aluop(aluop_4), .ex_op_a(op_a_4), .ex_op_b(op_b_4),
        .ex_store_data(store_4), .stall_count(count_4)
    );

    typedef struct {
        logic        rst, v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, as;
        logic [3:0]  aluop;
        logic        flush;
        logic [1:0]  fa, fb;
        logic [31:0] exm, wb;
    } stim_t;

    // Contents of the EX slot as an instruction record.
    typedef struct {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, as;
        logic [3:0]  aluop;
    } slot_t;

    typedef struct {
        logic        stall;
        logic [23:0] ctrl;
        logic [31:0] pc, opa, opb, st, cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sb[$];
    slot_t       ex_slot;
    longint      stalls;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        last_stall;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] own,
                                         input logic [31:0] exm, input logic [31:0] wb);
        if (sel == 2'b10) return exm;
        if (sel == 2'b01) return wb;
        return own;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst = 1'b0; s.v = $urandom_range(0, 7) != 0;
        s.pc = $urandom; s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
        s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom_range(0, 3));
        s.rw = 1'($urandom); s.mr = 1'($urandom); s.mw = 1'($urandom); s.as = 1'($urandom);
        s.aluop = 4'($urandom); s.flush = $urandom_range(0, 9) == 0;
        s.fa = 2'($urandom); s.fb = 2'($urandom); s.exm = $urandom; s.wb = $urandom;
        return s;
    endfunction

    // Apply one cycle of stimulus, predict the outputs seen this cycle, then advance the model.
    task automatic drive(input stim_t s);
        exp_t  e;
        logic  uses_load;
        logic [31:0] fb_val;
        reset = s.rst; id_valid = s.v; id_pc = s.pc; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_rd = s.rd; id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm;
        id_regwrite = s.rw; id_memread = s.mr; id_memwrite = s.mw; id_alusrc = s.as;
        id_aluop = s.aluop; flush = s.flush; forwardA = s.fa; forwardB = s.fb;
        ex_mem_alu_result = s.exm; wb_data = s.wb;

        uses_load = ex_slot.v && ex_slot.mr && ex_slot.rd != 0 && s.v &&
                    (ex_slot.rd == s.rs1 || ex_slot.rd == s.rs2);
        fb_val  = pick(s.fb, ex_slot.d2, s.exm, s.wb);
        e.stall = uses_load && !s.flush && !s.rst;
        e.ctrl  = {ex_slot.v, ex_slot.rs1, ex_slot.rs2, ex_slot.rd,
                   ex_slot.rw, ex_slot.mr, ex_slot.mw, ex_slot.as, ex_slot.aluop};
        e.pc    = ex_slot.pc;
        e.opa   = pick(s.fa, ex_slot.d1, s.exm, s.wb);
        e.opb   = ex_slot.as ? ex_slot.imm : fb_val;
        e.st    = fb_val;
        e.cnt   = 32'(stalls);
        e.cnt4  = (stalls > 15) ? 4'd15 : 4'(stalls);
        sb.push_back(e);
        last_stall = e.stall;

        if (s.rst) begin
            ex_slot = '{default: '0};
            stalls  = 0;
        end else if (s.flush || uses_load) begin
            ex_slot = '{default: '0};
            if (!s.flush) stalls++;
        end else begin
            ex_slot = '{v: s.v, pc: s.pc, d1: s.d1, d2: s.d2, imm: s.imm,
                        rs1: s.rs1, rs2: s.rs2, rd: s.rd,
                        rw: s.v & s.rw, mr: s.v & s.mr, mw: s.v & s.mw, as: s.v & s.as,
                        aluop: s.v ? s.aluop : 4'd0};
        end
        @(negedge clk);
        #1;
    endtask

    function automatic stim_t quiet(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd, input logic mr);
        stim_t s;
        s = rand_stim();
        s.v = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.mr = mr;
        s.flush = 1'b0; s.fa = 2'b00; s.fb = 2'b00;
        return s;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("stall_if_id", 64'(stall_if_id), 64'(e.stall));
                chk("ex_regs", 64'({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
                                    ex_memwrite, ex_alusrc, ex_aluop}), 64'(e.ctrl));
                chk("ex_pc", 64'(ex_pc), 64'(e.pc));
                chk("ex_op_a", 64'(ex_op_a), 64'(e.opa));
                chk("ex_op_b", 64'(ex_op_b), 64'(e.opb));
                chk("ex_store_data", 64'(ex_store_data), 64'(e.st));
                chk("stall_count", 64'(stall_count), 64'(e.cnt));
                chk("stall_count_w4", 64'(count_4), 64'(e.cnt4));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of run, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        ex_slot = '{default: '0};
        stalls  = 0;
        last_stall = 1'b0;
        s = rand_stim(); s.rst = 1'b1;
        reset = 1'b1; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_regwrite = 1'b0;
        id_memread = 1'b0; id_memwrite = 1'b0; id_alusrc = 1'b0; id_aluop = '0;
        flush = 1'b0; forwardA = '0; forwardB = '0; ex_mem_alu_result = '0; wb_data = '0;
        @(negedge clk); @(negedge clk); #1;

        // Reset held with random inputs: everything reads zero.
        for (int unsigned i = 0; i < 2; i++) begin
            s = rand_stim(); s.rst = 1'b1; s.fa = 2'b00; s.fb = 2'b00;
            drive(s);
        end

        // Load x5 followed by a dependent add: one stall, bubble, then capture.
        drive(quiet(5'd1, 5'd2, 5'd5, 1'b1));
        s = quiet(5'd5, 5'd3, 5'd7, 1'b0);
        drive(s); drive(s); drive(quiet(5'd0, 5'd0, 5'd0, 1'b0));

        // Load to x0 never creates a hazard.
        drive(quiet(5'd1, 5'd1, 5'd0, 1'b1));
        drive(quiet(5'd0, 5'd0, 5'd8, 1'b0));

        // Hazard coinciding with a flush: flush wins, no stall counted.
        drive(quiet(5'd2, 5'd2, 5'd6, 1'b1));
        s = quiet(5'd6, 5'd6, 5'd9, 1'b0); s.flush = 1'b1;
        drive(s);
        drive(quiet(5'd0, 5'd0, 5'd0, 1'b0));

        // Forwarding selects, immediate override and the reserved 11 code.
        s = quiet(5'd10, 5'd11, 5'd12, 1'b0);
        s.d1 = 32'h1111_1111; s.d2 = 32'h2222_2222; s.as = 1'b1; s.imm = 32'h10;
        drive(s);
        s.fa = 2'b10; s.exm = 32'hDEAD_BEEF; s.fb = 2'b01; s.wb = 32'h1234;
        drive(s);
        s.fa = 2'b11; s.fb = 2'b11;
        drive(s);

        // Back-to-back load-use pairs push the narrow counter into saturation.
        for (int unsigned i = 0; i < 20; i++) begin
            drive(quiet(5'd0, 5'd0, 5'd7, 1'b1));
            s = quiet(5'd7, 5'd0, 5'd3, 1'b0);
            drive(s); drive(s);
        end

        // Random traffic; a stalled ID instruction is held upstream.
        s = rand_stim();
        for (int unsigned i = 0; i < 300; i++) begin
            stim_t n;
            n = rand_stim();
            n.rst = $urandom_range(0, 59) == 0;
            if (last_stall) begin
                n.v = s.v; n.pc = s.pc; n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd;
                n.d1 = s.d1; n.d2 = s.d2; n.imm = s.imm; n.rw = s.rw; n.mr = s.mr;
                n.mw = s.mw; n.as = s.as; n.aluop = s.aluop;
            end
            s = n;
            drive(s);
        end

        @(negedge clk); @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
